// File: rtl/test_capture_buffer_pkg.sv
// Shared definitions for the audio test-tap capture buffer: FSM encoding and
// cap_status bit positions (also used by the CPU register map).
package test_capture_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_CAPTURE   = 2'd2,
    ST_DONE      = 2'd3
  } cap_state_e;

  localparam int STAT_WAITING   = 0;
  localparam int STAT_CAPTURING = 1;
  localparam int STAT_DONE      = 2;
  localparam int STAT_UNDERFLOW = 3;

endpackage

// File: rtl/test_capture_buffer_capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port,
// written so synthesis maps it onto block RAM.
module capture_ram #(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/test_capture_buffer.sv
// Trigger-armed capture of the audio test tap into RAM, with byte-wide CPU
// readback of the captured block one word at a time.
module test_capture_buffer
  import test_capture_buffer_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     din_valid,
  input  logic [DATA_W-1:0]        din,
  input  logic                     arm,
  input  logic                     trig_mode,
  input  logic [14:0]              threshold,
  input  logic                     rd_stb,
  output logic [7:0]               rd_lsb_data,
  output logic [7:0]               rd_msb_data,
  output logic [7:0]               cap_status,
  output logic [$clog2(DEPTH):0]   cap_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  cap_state_e        state, state_nx;
  logic              arm_q, arm_rise;
  logic [AW-1:0]     rd_ptr;
  logic              rd_blk, underflow;
  logic              wr_en, rd_adv, set_uflow, rd_last;
  logic [DATA_W-1:0] rd_q, rd_word;
  logic [DATA_W-1:0] din_neg, din_mag;
  logic              mag_hit;

  assign arm_rise = arm & ~arm_q;

  // Two's-complement magnitude; the most negative code saturates to max positive.
  assign din_neg = ~din + DATA_W'(1);
  always_comb begin
    din_mag = din;
    if (din[DATA_W-1])
      din_mag = (din == {1'b1, {(DATA_W-1){1'b0}}}) ? {1'b0, {(DATA_W-1){1'b1}}} : din_neg;
  end
  assign mag_hit = (din_mag >= DATA_W'(threshold));

  assign rd_last = ({1'b0, rd_ptr} == cap_count - CNT_W'(1));

  always_comb begin
    state_nx  = state;
    wr_en     = 1'b0;
    rd_adv    = 1'b0;
    set_uflow = 1'b0;
    if (!arm) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      if (arm_rise) state_nx = ST_WAIT_TRIG;
        ST_WAIT_TRIG: if (din_valid && (!trig_mode || mag_hit)) begin
          wr_en    = 1'b1;
          state_nx = ST_CAPTURE;
        end
        ST_CAPTURE:   if (din_valid) begin
          wr_en = 1'b1;
          if (cap_count == CNT_W'(DEPTH - 1)) state_nx = ST_DONE;
        end
        ST_DONE:      if (rd_stb && !rd_blk) begin
          if (rd_last) set_uflow = 1'b1;
          else         rd_adv    = 1'b1;
        end
        default:      state_nx = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      arm_q     <= 1'b0;
      cap_count <= '0;
      rd_ptr    <= '0;
      rd_blk    <= 1'b0;
      underflow <= 1'b0;
      rd_word   <= '0;
    end else begin
      arm_q <= arm;
      if (!arm) begin
        cap_count <= '0;
        rd_ptr    <= '0;
        rd_blk    <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wr_en)     cap_count <= cap_count + CNT_W'(1);
        if (rd_adv)    rd_ptr    <= rd_ptr + AW'(1);
        if (set_uflow) underflow <= 1'b1;
        // one-cycle lockout after an advance, while the new word is in flight
        rd_blk <= rd_adv;
      end
      if (state == ST_DONE) rd_word <= rd_q;
    end
  end

  capture_ram #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_en & ~reset),
    .waddr (cap_count[AW-1:0]),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (rd_q)
  );

  always_comb begin
    cap_status                 = '0;
    cap_status[STAT_WAITING]   = (state == ST_WAIT_TRIG);
    cap_status[STAT_CAPTURING] = (state == ST_CAPTURE);
    cap_status[STAT_DONE]      = (state == ST_DONE);
    cap_status[STAT_UNDERFLOW] = underflow;
  end

  assign rd_lsb_data = rd_word[7:0];
  assign rd_msb_data = rd_word[15:8];

endmodule

// File: tb/tb_test_capture_buffer.sv
// Directed bench for test_capture_buffer at DEPTH = 16.
module tb_test_capture_buffer;

  localparam int DEPTH  = 16;
  localparam int DATA_W = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        din_valid;
  logic [15:0] din;
  logic        arm;
  logic        trig_mode;
  logic [14:0] threshold;
  logic        rd_stb;
  logic [7:0]  rd_lsb_data, rd_msb_data, cap_status;
  logic [4:0]  cap_count;

  int ncmp = 0;
  int nerr = 0;

  test_capture_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .din_valid   (din_valid),
    .din         (din),
    .arm         (arm),
    .trig_mode   (trig_mode),
    .threshold   (threshold),
    .rd_stb      (rd_stb),
    .rd_lsb_data (rd_lsb_data),
    .rd_msb_data (rd_msb_data),
    .cap_status  (cap_status),
    .cap_count   (cap_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [15:0] exp);
    chk({tag, ".lsb"}, {24'd0, rd_lsb_data}, {24'd0, exp[7:0]});
    chk({tag, ".msb"}, {24'd0, rd_msb_data}, {24'd0, exp[15:8]});
  endtask

  task automatic send(input logic [15:0] d);
    din_valid = 1'b1;
    din       = d;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic strobe_and_settle();
    rd_stb = 1'b1;
    tick();
    rd_stb = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    reset = 1'b1; din_valid = 1'b0; din = '0; arm = 1'b0;
    trig_mode = 1'b0; threshold = '0; rd_stb = 1'b0;
    tick(); tick();
    chk("reset.status", cap_status, 8'h00);
    chk("reset.count", cap_count, 5'd0);
    chk_word("reset.word", 16'h0000);
    reset = 1'b0;
    tick();

    // mode 0: capture 1..16 back to back, with a stray read strobe mid-capture
    arm = 1'b1;
    tick();
    chk("m0.waiting", cap_status, 8'h01);
    for (int i = 1; i <= 16; i++) begin
      din_valid = 1'b1;
      din       = 16'(i);
      rd_stb    = (i == 5);
      tick();
      if (i == 1) begin
        chk("m0.capturing", cap_status, 8'h02);
        chk("m0.count1", cap_count, 5'd1);
      end
    end
    din_valid = 1'b0; rd_stb = 1'b0;
    chk("m0.done", cap_status, 8'h04);
    chk("m0.count16", cap_count, 5'd16);
    tick(); tick();
    chk_word("m0.word0", 16'h0001);

    // two consecutive strobes advance by one word only
    rd_stb = 1'b1;
    tick(); tick();
    rd_stb = 1'b0;
    tick(); tick();
    chk_word("m0.dblstb", 16'h0002);
    chk("m0.dblstb.status", cap_status, 8'h04);
    for (int k = 3; k <= 16; k++) begin
      strobe_and_settle();
      chk_word("m0.read", 16'(k));
    end
    chk("m0.no_uflow", cap_status, 8'h04);
    strobe_and_settle();
    chk("m0.uflow", cap_status, 8'h0C);
    chk_word("m0.hold15", 16'h0010);

    arm = 1'b0;
    tick();
    chk("clr.status", cap_status, 8'h00);
    chk("clr.count", cap_count, 5'd0);

    // mode 1 threshold trigger
    trig_mode = 1'b1; threshold = 15'h1000; arm = 1'b1;
    tick();
    send(16'h0100);
    chk("m1.below1", cap_status, 8'h01);
    send(16'hF800);
    chk("m1.below2", cap_status, 8'h01);
    chk("m1.count0", cap_count, 5'd0);
    send(16'hEFFF);
    chk("m1.trig", cap_status, 8'h02);
    chk("m1.count1", cap_count, 5'd1);
    for (int k = 2; k <= 16; k++) send(16'(k));
    chk("m1.done", cap_status, 8'h04);
    tick(); tick();
    chk_word("m1.word0", 16'hEFFF);
    strobe_and_settle();
    chk_word("m1.word1", 16'h0002);

    // arm dropped with a sample on word 5: clear wins
    arm = 1'b0;
    tick();
    trig_mode = 1'b0; arm = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) send(16'h0200 + 16'(i));
    chk("abort.count5", cap_count, 5'd5);
    arm = 1'b0; din_valid = 1'b1; din = 16'h0BAD;
    tick();
    din_valid = 1'b0;
    chk("abort.status", cap_status, 8'h00);
    chk("abort.count", cap_count, 5'd0);
    arm = 1'b1;
    tick();
    chk("rearm.waiting", cap_status, 8'h01);
    for (int i = 0; i < 16; i++) send(16'h0300 + 16'(i));
    chk("rearm.done", cap_status, 8'h04);
    chk("rearm.count", cap_count, 5'd16);
    tick(); tick();
    chk_word("rearm.word0", 16'h0300);

    // most negative sample saturates to 0x7FFF and meets a 0x7FFF threshold
    arm = 1'b0;
    tick();
    trig_mode = 1'b1; threshold = 15'h7FFF; arm = 1'b1;
    tick();
    send(16'h7FFE);
    chk("neg.below", cap_status, 8'h01);
    send(16'h8000);
    chk("neg.trig", cap_status, 8'h02);
    for (int i = 0; i < 15; i++) send(16'h0001);
    chk("neg.done", cap_status, 8'h04);
    tick(); tick();
    chk_word("neg.word0", 16'h8000);

    // reset mid-capture aborts; arm held high re-arms right after reset
    arm = 1'b0;
    tick();
    trig_mode = 1'b0; arm = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) send(16'h0400);
    chk("rst.count3", cap_count, 5'd3);
    reset = 1'b1;
    tick();
    chk("rst.status", cap_status, 8'h00);
    chk("rst.count", cap_count, 5'd0);
    reset = 1'b0;
    tick();
    chk("rst.rearm", cap_status, 8'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
